inverse_seq_ctrl: RTL and testbench
===================================

// Module: inverse_seq_ctrl
// PURPOSE
//  Sequencer for the 5x5 matrix-inverse datapath. On start it loads N*N elements from
//  the coefficient ROM into the datapath input array and pulses the datapath start.
//  It then waits for done/singular and streams the N*N inverse words out on a
//  valid/ready port in row-major order. Sits between the system controller and the datapath.
// PARAMETERS
//  N        5     matrix dimension; N*N elements, N*N <= 31
//  DATA_W   32    element width
//  ROM_LAT  1     ROM read latency in cycles (1..4)
//  TIMEOUT  1024  max cycles in WAIT before error abort
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       synchronous, active-high
//  start          in   1       begin a run; sampled only in IDLE
//  busy           out  1       high in any state except IDLE
//  rom_addr       out  5       ROM address
//  rom_data       in   DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr
//  ld_we          out  1       datapath input-array write enable
//  ld_addr        out  5       datapath input index, 1..N*N
//  ld_data        out  DATA_W  write data (= rom_data)
//  calc_start     out  1       one-cycle pulse to start the datapath
//  calc_done      in   1       datapath result valid (level or pulse)
//  calc_singular  in   1       qualified by calc_done: matrix is singular
//  res_addr       out  5       result read index 0..N*N-1; res_data is combinational
//  res_data       in   DATA_W  inverse element at res_addr
//  out_valid      out  1       result stream valid
//  out_ready      in   1       downstream accept
//  out_data       out  DATA_W  inverse element
//  out_index      out  5       row-major index of out_data
//  done           out  1       one-cycle pulse at end of every run
//  singular       out  1       sticky; set on singular result, cleared on next accepted start
//  timeout_err    out  1       sticky; set on WAIT timeout, cleared on next accepted start
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including rom_addr, ld_addr, res_addr and out_index.
//  FSM: IDLE -> LOAD -> KICK -> WAIT -> READ -> IDLE.
//  - IDLE: start=1 -> LOAD; clears singular and timeout_err.
//  - LOAD: rom_addr steps 1..N*N, one per cycle. ld_we/ld_addr are the issued address
//    delayed ROM_LAT cycles, with ld_data=rom_data. LOAD lasts N*N+ROM_LAT cycles and
//    exits after the write for index N*N. rom_addr returns to 0 after N*N is issued.
//  - KICK: calc_start=1 for exactly one cycle, then WAIT. The wait counter clears.
//  - WAIT: calc_done=1 with calc_singular=1 -> set singular, pulse done, go to IDLE (no readout).
//    calc_done=1 with calc_singular=0 -> READ, index=0.
//    The counter reaching TIMEOUT with no calc_done -> set timeout_err, pulse done, go to IDLE.
//    If calc_done arrives on the timeout cycle, calc_done wins.
//  - READ: res_addr=index. out_data/out_index are registered from res_data/index, so
//    out_valid rises 1 cycle after entering READ. out_data and out_index hold stable while
//    out_valid=1 and out_ready=0. On a handshake (valid&ready) the index increments and the
//    next word is presented the following cycle with no bubble. The handshake at index
//    N*N-1 drops out_valid, pulses done and returns to IDLE.
//  - start while busy is ignored (no queueing).
//  - reset in any state aborts immediately to IDLE with reset values. No done pulse.
//    Partially loaded datapath contents are left undefined.
//  - done is never asserted together with out_valid.
// TESTING
//  1. ROM 1..25, ROM_LAT=1, start pulse -> ld_we for 25 cycles, ld_addr 1..25 equal to ROM
//     contents; calc_start one cycle later.
//  2. calc_done 10 cycles after calc_start, out_ready=1 -> 25 back-to-back words,
//     out_index 0..24, done on the cycle after the last.
//  3. out_ready toggling 1/0 every cycle -> out_data held while stalled; 25 handshakes,
//     no duplicates, no drops.
//  4. calc_done with calc_singular=1 -> singular=1, done pulse, out_valid never rises,
//     busy=0 next cycle.
//  5. TIMEOUT=16, calc_done never asserted -> timeout_err=1 16 cycles after calc_start;
//     the next start clears it.
//  6. reset at LOAD index 12, and again mid-READ -> all outputs 0 next cycle; a fresh run
//     then completes normally.

Source files
------------

// File: rtl/inverse_seq_ctrl.sv
// inverse_seq_ctrl
// Sequencer for the NxN matrix-inverse datapath. A run loads N*N coefficients
// from the ROM into the datapath input array, pulses the datapath start,
// waits for a result (or gives up after TIMEOUT cycles) and streams the
// inverse out in row-major order on a valid/ready port.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start / busy       run request (taken only when idle) / run in progress
//   rom_addr, rom_data coefficient ROM read port (data ROM_LAT cycles later)
//   ld_we, ld_addr,    datapath input-array write port, index 1..N*N
//   ld_data
//   calc_start         one-cycle datapath start pulse
//   calc_done,         datapath result valid; singular flag qualified by done
//   calc_singular
//   res_addr, res_data combinational result read port, index 0..N*N-1
//   out_valid, out_ready, out_data, out_index   result stream
//   done               one-cycle pulse at the end of every run
//   singular,          sticky run status, cleared by the next accepted start
//   timeout_err
module inverse_seq_ctrl #(
    parameter int N       = 5,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [4:0]        rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ld_we,
    output logic [4:0]        ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              calc_start,
    input  logic              calc_done,
    input  logic              calc_singular,
    output logic [4:0]        res_addr,
    input  logic [DATA_W-1:0] res_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_index,
    output logic              done,
    output logic              singular,
    output logic              timeout_err
);

    localparam int NN = N * N;
    localparam logic [4:0] LAST_LD  = 5'(NN);
    localparam logic [4:0] LAST_RES = 5'(NN - 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_READ
    } state_t;

    state_t state;
    state_t state_next;

    logic [ROM_LAT-1:0] pipe_v;
    logic [4:0]         pipe_a [ROM_LAT];
    logic [4:0]         idx;
    logic [CNT_W-1:0]   wait_cnt;

    logic start_ok;
    logic load_last;
    logic calc_ok;
    logic calc_bad;
    logic time_up;
    logic handshake;
    logic finish;
    logic fetch;

    assign start_ok  = (state == S_IDLE) && start;
    assign load_last = (state == S_LOAD) && ld_we && (ld_addr == LAST_LD);
    assign calc_ok   = (state == S_WAIT) && calc_done && !calc_singular;
    assign calc_bad  = (state == S_WAIT) && calc_done && calc_singular;
    // calc_done takes priority over a timeout landing on the same cycle
    assign time_up   = (state == S_WAIT) && !calc_done && (wait_cnt == CNT_LIMIT);
    assign handshake = out_valid && out_ready;
    assign finish    = (state == S_READ) && handshake && (out_index == LAST_RES);
    // refill the output register on entry to READ and after every accepted
    // word except the last one
    assign fetch     = (state == S_READ) && (!out_valid || handshake) && !finish;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        calc_start = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: if (load_last) state_next = S_KICK;
            S_KICK: begin
                calc_start = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (calc_ok) begin
                    state_next = S_READ;
                end else if (calc_bad || time_up) begin
                    state_next = S_IDLE;
                end
            end
            S_READ: if (finish) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ROM address issue plus a delay line that lines the issued address up
    // with the ROM data ROM_LAT cycles later. rom_addr is only non-zero while
    // addresses are being issued, so it doubles as the issue-valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            pipe_v   <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe_a[k] <= '0;
            end
        end else begin
            if (start_ok) begin
                rom_addr <= 5'd1;
            end else if ((state == S_LOAD) && (rom_addr != 5'd0)) begin
                rom_addr <= (rom_addr == LAST_LD) ? 5'd0 : rom_addr + 5'd1;
            end
            pipe_v[0] <= (state == S_LOAD) && (rom_addr != 5'd0);
            pipe_a[0] <= rom_addr;
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_a[k] <= pipe_a[k-1];
            end
        end
    end

    assign ld_we   = pipe_v[ROM_LAT-1];
    assign ld_addr = pipe_a[ROM_LAT-1];
    assign ld_data = ld_we ? rom_data : '0;

    // wait_cnt counts cycles since calc_start, so it is 1 on the first WAIT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_KICK) begin
            wait_cnt <= CNT_W'(1);
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Result stream: idx is the next result to fetch, out_* is the word on offer
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else if (calc_ok) begin
            idx <= '0;
        end else if (fetch) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_index <= idx;
            if (idx != LAST_RES) begin
                idx <= idx + 5'd1;
            end
        end else if (finish) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end
    end

    assign res_addr = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            singular    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= finish || calc_bad || time_up;
            if (start_ok) begin
                singular    <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (calc_bad) begin
                singular <= 1'b1;
            end
            if (time_up) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inverse_seq_ctrl.sv
// tb_inverse_seq_ctrl
// Self-checking bench for inverse_seq_ctrl. A table of run scenarios
// (ready pattern, datapath latency, singular flag, expected outcome) is
// replayed against random ROM and result contents; the expected load
// sequence and output stream come from the memories themselves. Hand-written
// sequences cover reset during LOAD and during READ.
module tb_inverse_seq_ctrl;

    localparam int N       = 5;
    localparam int DATA_W  = 32;
    localparam int ROM_LAT = 1;
    localparam int TIMEOUT = 16;
    localparam int NN      = N * N;

    logic              clk;
    logic              reset;
    logic              start;
    logic              busy;
    logic [4:0]        rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              ld_we;
    logic [4:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              calc_start;
    logic              calc_done;
    logic              calc_singular;
    logic [4:0]        res_addr;
    logic [DATA_W-1:0] res_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_index;
    logic              done;
    logic              singular;
    logic              timeout_err;

    inverse_seq_ctrl #(
        .N(N), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .calc_start(calc_start), .calc_done(calc_done), .calc_singular(calc_singular),
        .res_addr(res_addr), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .done(done), .singular(singular), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] rom_mem  [32];
    logic [DATA_W-1:0] res_mem  [32];
    logic [DATA_W-1:0] rom_pipe [ROM_LAT];

    always @(posedge clk) begin
        rom_pipe[0] <= rom_mem[rom_addr];
        for (int k = 1; k < ROM_LAT; k++) begin
            rom_pipe[k] <= rom_pipe[k-1];
        end
    end
    assign rom_data = rom_pipe[ROM_LAT-1];
    assign res_data = res_mem[res_addr];

    int checks = 0;
    int errors = 0;
    bit prev_sing = 1'b0;
    bit prev_to   = 1'b0;

    // ready_mode: 0 always ready, 1 toggling, 2 random; done_delay < 0: never
    typedef struct {
        int ready_mode;
        int done_delay;
        bit sing;
        bit identity;
        int exp_words;
        bit exp_sing;
        bit exp_to;
    } scen_t;

    scen_t tbl [9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit identity);
        for (int i = 0; i < 32; i++) begin
            rom_mem[i] = identity ? 32'(i) : $urandom;
            res_mem[i] = $urandom;
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput($sformatf("%s_busy", tag), busy, 0);
        checkOutput($sformatf("%s_rom_addr", tag), rom_addr, 0);
        checkOutput($sformatf("%s_ld_we", tag), ld_we, 0);
        checkOutput($sformatf("%s_ld_addr", tag), ld_addr, 0);
        checkOutput($sformatf("%s_ld_data", tag), ld_data, 0);
        checkOutput($sformatf("%s_calc_start", tag), calc_start, 0);
        checkOutput($sformatf("%s_res_addr", tag), res_addr, 0);
        checkOutput($sformatf("%s_out_valid", tag), out_valid, 0);
        checkOutput($sformatf("%s_out_data", tag), out_data, 0);
        checkOutput($sformatf("%s_out_index", tag), out_index, 0);
        checkOutput($sformatf("%s_done", tag), done, 0);
        checkOutput($sformatf("%s_singular", tag), singular, 0);
        checkOutput($sformatf("%s_timeout_err", tag), timeout_err, 0);
    endtask

    // One full run. Cycle 0 is the first cycle after start is sampled; every
    // cycle inputs are driven first, then outputs are compared at the same
    // #1-after-edge point so the chosen out_ready is the one the DUT sees.
    task automatic runScenario(input scen_t s);
        int cs = -1;
        int calc_drive = -1;
        int ld_next = 1;
        int out_next = 0;
        int first_valid = -1;
        int last_hs = -1;
        int done_cyc = -1;
        int kicks = 0;

        applyStimulus(s.identity);
        checkOutput("sticky_singular_hold", singular, prev_sing);
        checkOutput("sticky_timeout_hold", timeout_err, prev_to);
        checkOutput("idle_before_start", busy, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_clears_singular", singular, 0);
        checkOutput("start_clears_timeout", timeout_err, 0);
        checkOutput("first_rom_addr", rom_addr, 1);

        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            // extra starts while busy must be ignored
            start         = (cyc == 3) || (cs >= 0 && cyc == cs + 1);
            calc_done     = (calc_drive >= 0) && (cyc == calc_drive);
            calc_singular = calc_done ? s.sing : 1'($urandom_range(0, 1));
            case (s.ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase

            if (ld_we) begin
                checkOutput("ld_cycle", cyc, ld_next - 1 + ROM_LAT);
                checkOutput("ld_addr", ld_addr, ld_next);
                checkOutput("ld_data", ld_data, rom_mem[ld_next]);
                ld_next++;
            end
            if (calc_start) begin
                kicks++;
                if (cs < 0) begin
                    cs = cyc;
                    checkOutput("calc_start_cycle", cyc, NN + ROM_LAT);
                    calc_drive = (s.done_delay >= 0) ? cyc + s.done_delay : -1;
                end
            end
            if (out_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    checkOutput("first_valid_cycle", cyc, calc_drive + 2);
                end
                checkOutput("out_index", out_index, out_next);
                checkOutput("out_data", out_data, res_mem[out_next & 31]);
                checkOutput("done_with_valid", done, 0);
                if (out_ready) begin
                    out_next++;
                    last_hs = cyc;
                end
            end
            if (done) begin
                done_cyc = cyc;
                checkOutput("busy_at_done", busy, 0);
            end else begin
                checkOutput("busy_in_run", busy, 1);
                @(posedge clk); #1;
            end
        end

        start     = 1'b0;
        calc_done = 1'b0;
        out_ready = 1'b0;
        checkOutput("run_finished", done_cyc >= 0, 1);
        checkOutput("ld_count", ld_next - 1, NN);
        checkOutput("calc_start_pulses", kicks, 1);
        checkOutput("words_out", out_next, s.exp_words);
        checkOutput("singular_flag", singular, s.exp_sing);
        checkOutput("timeout_flag", timeout_err, s.exp_to);
        if (s.exp_to) begin
            checkOutput("timeout_delay", done_cyc - cs, TIMEOUT);
        end else if (s.exp_sing) begin
            checkOutput("singular_done_cycle", done_cyc, calc_drive + 1);
        end else begin
            checkOutput("last_done_cycle", done_cyc, last_hs + 1);
        end
        if (s.exp_words == 0) begin
            checkOutput("no_valid_seen", first_valid, -1);
        end
        @(posedge clk); #1;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("idle_after_run", busy, 0);
        prev_sing = s.exp_sing;
        prev_to   = s.exp_to;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        scen_t fresh;
        tbl[0] = '{0, 10, 1'b0, 1'b1, NN, 1'b0, 1'b0};
        tbl[1] = '{1, 10, 1'b0, 1'b0, NN, 1'b0, 1'b0};
        tbl[2] = '{0, 5,  1'b1, 1'b0, 0,  1'b1, 1'b0};
        tbl[3] = '{2, 3,  1'b0, 1'b0, NN, 1'b0, 1'b0};
        tbl[4] = '{0, -1, 1'b0, 1'b0, 0,  1'b0, 1'b1};
        tbl[5] = '{2, TIMEOUT - 1, 1'b0, 1'b0, NN, 1'b0, 1'b0};
        tbl[6] = '{0, TIMEOUT, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tbl[7] = '{1, 1,  1'b1, 1'b0, 0,  1'b1, 1'b0};
        tbl[8] = '{1, 4,  1'b0, 1'b0, NN, 1'b0, 1'b0};
        fresh  = '{0, 7,  1'b0, 1'b0, NN, 1'b0, 1'b0};

        reset         = 1'b1;
        start         = 1'b0;
        calc_done     = 1'b0;
        calc_singular = 1'b0;
        out_ready     = 1'b0;
        applyStimulus(1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkIdleZero("por");
        reset = 1'b0;

        for (int t = 0; t < 9; t++) begin
            $display("[TB] scenario %0d", t);
            runScenario(tbl[t]);
        end

        // reset while the ROM address is 12
        $display("[TB] reset during LOAD");
        applyStimulus(1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 60 && rom_addr != 5'd12; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("reached_load_12", rom_addr, 12);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkIdleZero("rst_load");
        prev_sing = 1'b0;
        prev_to   = 1'b0;
        runScenario(fresh);

        // singular run first so the sticky flag is set before the READ reset
        runScenario(tbl[2]);
        $display("[TB] reset during READ");
        applyStimulus(1'b0);
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 80 && !calc_start; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("reached_kick", calc_start, 1);
        @(posedge clk); #1;
        calc_done     = 1'b1;
        calc_singular = 1'b0;
        @(posedge clk); #1;
        calc_done = 1'b0;
        for (int i = 0; i < 40 && !(out_valid && out_index == 5'd8); i++) begin
            @(posedge clk); #1;
        end
        checkOutput("reached_read_8", out_index, 8);
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b0;
        checkIdleZero("rst_read");
        prev_sing = 1'b0;
        prev_to   = 1'b0;
        runScenario(fresh);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
